// File: rtl/stdcore_rfifo_pkg.sv
// Shared helpers for the multi-channel registered-output FIFO.
// Holds clog2_f, the pointer-wrap test and the default occupancy type.
package stdcore_rfifo_pkg;

    // Ceiling log2; usable in parameter and port-width expressions.
    function automatic int clog2_f(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // True when a pointer sits on its last slot and must wrap to 0.
    // The compare form also covers depths that are not powers of two.
    function automatic bit ptr_last(input int ptr, input int depth);
        return ptr == depth - 1;
    endfunction

    localparam int DEF_DEPTH = 4;

    // Occupancy type for the default depth (0..DEPTH needs DEPTH+1 codes).
    typedef logic [clog2_f(DEF_DEPTH+1)-1:0] occ_t;

endpackage

// File: rtl/stdcore_rfifo_lane.sv
// One FIFO channel: pointers, occupancy, memory and registered output.
// Ports: p/p_val/p_rdy/p_prdy producer side, c/c_val/c_rdy consumer, cnt, err with STDCORE_RFIFO_MC_ERR_EN.
module stdcore_rfifo_lane
    import stdcore_rfifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int PRE   = 1,
    parameter int CW    = clog2_f(DEPTH+1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          rst_n,
    input  logic [DW-1:0] p,
    input  logic          p_val,
    output logic          p_rdy,
    output logic          p_prdy,
    output logic [DW-1:0] c,
    output logic          c_val,
    input  logic          c_rdy,
    output logic [CW-1:0] cnt
`ifdef STDCORE_RFIFO_MC_ERR_EN
    ,
    output logic          err
`endif
);

    localparam int PW = (clog2_f(DEPTH) < 1) ? 1 : clog2_f(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW-1:0] r_rp1;
    logic [CW-1:0] r_cnt;
    logic          r_c_val;
    logic          r_p_rdy;
    logic          r_p_prdy;
    logic [DW-1:0] r_c;

    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_nxt;
    logic [CW:0]   w_rem;
    logic          w_thru;
    logic [PW-1:0] w_wp_n;
    logic [PW-1:0] w_rp1_n;
    logic [PW-1:0] w_rd;
    logic [DW-1:0] w_c_n;

    assign w_push  = p_val & r_p_rdy;
    assign w_pop   = r_c_val & c_rdy;
    assign w_rem   = {1'b0, r_cnt} - (CW+1)'(w_pop);
    assign w_nxt   = w_rem + (CW+1)'(w_push);
    // Lane is (or becomes) empty ahead of this push: bypass the memory.
    assign w_thru  = w_push && (w_rem == '0);
    assign w_wp_n  = ptr_last(int'(r_wp), DEPTH) ? '0 : r_wp + 1'b1;
    assign w_rp1_n = ptr_last(int'(r_rp1), DEPTH) ? '0 : r_rp1 + 1'b1;
    // On a pop the head moves on, so the next word sits at rdptr+1.
    assign w_rd    = w_pop ? r_rp1 : r_rp;
    assign w_c_n   = w_thru ? p : r_mem[w_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= p;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_rp1    <= PW'(1);
            r_cnt    <= '0;
            r_c_val  <= 1'b0;
            r_p_rdy  <= 1'b0;
            r_p_prdy <= 1'b0;
            r_c      <= '0;
        end else if (!rst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_rp1    <= PW'(1);
            r_cnt    <= '0;
            r_c_val  <= 1'b0;
            r_p_rdy  <= 1'b0;
            r_p_prdy <= 1'b0;
            r_c      <= '0;
        end else begin
            if (w_push) begin
                r_wp <= w_wp_n;
            end
            if (w_pop) begin
                r_rp  <= r_rp1;
                r_rp1 <= w_rp1_n;
            end
            r_cnt    <= w_nxt[CW-1:0];
            r_c_val  <= (w_nxt != '0);
            r_p_rdy  <= (w_nxt < (CW+1)'(DEPTH));
            r_p_prdy <= (w_nxt < (CW+1)'(DEPTH-PRE));
            if (w_nxt != '0) begin
                r_c <= w_c_n;
            end
        end
    end

    assign p_rdy  = r_p_rdy;
    assign p_prdy = r_p_prdy;
    assign c      = r_c;
    assign c_val  = r_c_val;
    assign cnt    = r_cnt;

`ifdef STDCORE_RFIFO_MC_ERR_EN
    logic r_err;
    logic r_popped;

    // Underflow is only flagged once the lane has really been drained,
    // so an idle consumer holding c_rdy high after reset is not an error.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_err    <= 1'b0;
            r_popped <= 1'b0;
        end else if (!rst_n) begin
            r_err    <= 1'b0;
            r_popped <= 1'b0;
        end else begin
            if (w_pop) begin
                r_popped <= 1'b1;
            end
            if ((p_val && !r_p_rdy) ||
                (c_rdy && !r_c_val && r_popped)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule

// File: rtl/stdcore_rfifo_pre_mc.sv
// NCH independent registered-output FIFO lanes with per-lane pre-ready.
// Ports: clk, arst_n, rst_n, p/p_val/p_rdy/p_prdy, c/c_val/c_rdy, cnt; err with STDCORE_RFIFO_MC_ERR_EN.
module stdcore_rfifo_pre_mc
    import stdcore_rfifo_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    parameter  int PRE   = 1,
    parameter  int NCH   = 2,
    localparam int CW    = clog2_f(DEPTH+1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] p,
    input  logic [NCH-1:0]    p_val,
    output logic [NCH-1:0]    p_rdy,
    output logic [NCH-1:0]    p_prdy,
    output logic [NCH*DW-1:0] c,
    output logic [NCH-1:0]    c_val,
    input  logic [NCH-1:0]    c_rdy,
    output logic [NCH*CW-1:0] cnt
`ifdef STDCORE_RFIFO_MC_ERR_EN
    ,
    output logic [NCH-1:0]    err
`endif
);

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        stdcore_rfifo_lane #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .PRE   (PRE),
            .CW    (CW)
        ) u_lane (
            .clk    (clk),
            .arst_n (arst_n),
            .rst_n  (rst_n),
            .p      (p[g*DW +: DW]),
            .p_val  (p_val[g]),
            .p_rdy  (p_rdy[g]),
            .p_prdy (p_prdy[g]),
            .c      (c[g*DW +: DW]),
            .c_val  (c_val[g]),
            .c_rdy  (c_rdy[g]),
            .cnt    (cnt[g*CW +: CW])
`ifdef STDCORE_RFIFO_MC_ERR_EN
            ,
            .err    (err[g])
`endif
        );
    end

endmodule

// File: tb/tb_stdcore_rfifo_pre_mc.sv
// Directed vector bench for stdcore_rfifo_pre_mc (DW=8, DEPTH=4, PRE=1, NCH=2).
// Checks err too when STDCORE_RFIFO_MC_ERR_EN is defined.
module tb_stdcore_rfifo_pre_mc;
    import stdcore_rfifo_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        rst_n;
    logic [15:0] p;
    logic [1:0]  p_val;
    logic [1:0]  p_rdy;
    logic [1:0]  p_prdy;
    logic [15:0] c;
    logic [1:0]  c_val;
    logic [1:0]  c_rdy;
    logic [5:0]  cnt;
`ifdef STDCORE_RFIFO_MC_ERR_EN
    logic [1:0]  err;
`endif

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    stdcore_rfifo_pre_mc #(
        .DW    (8),
        .DEPTH (4),
        .PRE   (1),
        .NCH   (2)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .rst_n  (rst_n),
        .p      (p),
        .p_val  (p_val),
        .p_rdy  (p_rdy),
        .p_prdy (p_prdy),
        .c      (c),
        .c_val  (c_val),
        .c_rdy  (c_rdy),
        .cnt    (cnt)
`ifdef STDCORE_RFIFO_MC_ERR_EN
        ,
        .err    (err)
`endif
    );

    typedef struct {
        logic [1:0] pv;
        logic [1:0] cr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rn;
        logic [1:0] rdy;
        logic [1:0] prdy;
        logic [1:0] cv;
        logic [7:0] c0;
        logic [7:0] c1;
        occ_t       n0;
        occ_t       n1;
        logic [1:0] er;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic [1:0] pv, input logic [1:0] cr,
        input logic [7:0] d0, input logic [7:0] d1,
        input logic rn,
        input logic [1:0] rdy, input logic [1:0] prdy,
        input logic [1:0] cv,
        input logic [7:0] c0, input logic [7:0] c1,
        input int n0, input int n1,
        input logic [1:0] er);
        vec_t v;
        v.pv = pv;   v.cr = cr;
        v.d0 = d0;   v.d1 = d1;
        v.rn = rn;
        v.rdy = rdy; v.prdy = prdy;
        v.cv = cv;
        v.c0 = c0;   v.c1 = c1;
        v.n0 = occ_t'(n0);
        v.n1 = occ_t'(n1);
        v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        arst_n = 1'b0;
        rst_n  = 1'b1;
        p      = '0;
        p_val  = '0;
        c_rdy  = '0;

        // Fill and overflow lane 0, then drain it.
        tv.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00));
        tv.push_back(mk(2'b01, 2'b00, 8'h11, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'h11, 8'h00, 1, 0, 2'b00));
        tv.push_back(mk(2'b01, 2'b00, 8'h22, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'h11, 8'h00, 2, 0, 2'b00));
        tv.push_back(mk(2'b01, 2'b00, 8'h33, 8'h00, 1, 2'b11, 2'b10, 2'b01, 8'h11, 8'h00, 3, 0, 2'b00));
        tv.push_back(mk(2'b01, 2'b00, 8'h44, 8'h00, 1, 2'b10, 2'b10, 2'b01, 8'h11, 8'h00, 4, 0, 2'b00));
        tv.push_back(mk(2'b01, 2'b00, 8'h55, 8'h00, 1, 2'b10, 2'b10, 2'b01, 8'h11, 8'h00, 4, 0, 2'b01));
        tv.push_back(mk(2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b11, 2'b10, 2'b01, 8'h22, 8'h00, 3, 0, 2'b01));
        tv.push_back(mk(2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'h33, 8'h00, 2, 0, 2'b01));
        tv.push_back(mk(2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'h44, 8'h00, 1, 0, 2'b01));
        tv.push_back(mk(2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'h44, 8'h00, 0, 0, 2'b01));
        // Steady push+pop stream on lane 1.
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(2'b10, 2'b10, 8'h00, 8'(i), 1, 2'b11, 2'b11, 2'b10, 8'h44, 8'(i), 0, 1, 2'b01));
        tv.push_back(mk(2'b00, 2'b10, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'h44, 8'h09, 0, 0, 2'b01));
        // Lane 1 stream at occupancy 2: reads come from memory across the wrap.
        tv.push_back(mk(2'b10, 2'b00, 8'h00, 8'hA0, 1, 2'b11, 2'b11, 2'b10, 8'h44, 8'hA0, 0, 1, 2'b01));
        tv.push_back(mk(2'b10, 2'b00, 8'h00, 8'hA1, 1, 2'b11, 2'b11, 2'b10, 8'h44, 8'hA0, 0, 2, 2'b01));
        for (int i = 2; i < 7; i++)
            tv.push_back(mk(2'b10, 2'b10, 8'h00, 8'hA0 + 8'(i), 1, 2'b11, 2'b11, 2'b10, 8'h44, 8'hA0 + 8'(i-1), 0, 2, 2'b01));
        tv.push_back(mk(2'b00, 2'b10, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b10, 8'h44, 8'hA6, 0, 1, 2'b01));
        tv.push_back(mk(2'b00, 2'b10, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'h44, 8'hA6, 0, 0, 2'b01));
        // Write-through at cnt=1 with simultaneous pop.
        tv.push_back(mk(2'b01, 2'b00, 8'h5A, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'h5A, 8'hA6, 1, 0, 2'b01));
        tv.push_back(mk(2'b01, 2'b01, 8'hAB, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'hAB, 8'hA6, 1, 0, 2'b01));
        tv.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'hAB, 8'hA6, 1, 0, 2'b01));
        // Synchronous clear at cnt=3, then recovery.
        tv.push_back(mk(2'b01, 2'b00, 8'hC1, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'hAB, 8'hA6, 2, 0, 2'b01));
        tv.push_back(mk(2'b01, 2'b00, 8'hC2, 8'h00, 1, 2'b11, 2'b10, 2'b01, 8'hAB, 8'hA6, 3, 0, 2'b01));
        tv.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00));
        tv.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00));
        tv.push_back(mk(2'b01, 2'b00, 8'hD1, 8'h00, 1, 2'b11, 2'b11, 2'b01, 8'hD1, 8'h00, 1, 0, 2'b00));
        tv.push_back(mk(2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'hD1, 8'h00, 0, 0, 2'b00));
        tv.push_back(mk(2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b11, 2'b11, 2'b00, 8'hD1, 8'h00, 0, 0, 2'b01));

        step();
        step();
        chk("reset_state", {16'h0, p_rdy, p_prdy, c_val, cnt, 2'b00},
            32'h0);
        chk("reset_c", {16'h0, c}, 32'h0);
        arst_n = 1'b1;

        foreach (tv[i]) begin
            p_val = tv[i].pv;
            c_rdy = tv[i].cr;
            p     = {tv[i].d1, tv[i].d0};
            rst_n = tv[i].rn;
            step();
            chk($sformatf("vec%0d", i),
                {4'h0, p_rdy, p_prdy, c_val, c[7:0], c[15:8], cnt[2:0], cnt[5:3]},
                {4'h0, tv[i].rdy, tv[i].prdy, tv[i].cv, tv[i].c0, tv[i].c1, tv[i].n0, tv[i].n1});
`ifdef STDCORE_RFIFO_MC_ERR_EN
            chk($sformatf("vec%0d_err", i), {30'h0, err}, {30'h0, tv[i].er});
`endif
        end
        p_val = '0;
        c_rdy = '0;
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a cycle.
        p_val = 2'b10;
        p     = 16'h7700;
        step();
        p_val = '0;
        chk("pre_arst_cnt1", {29'h0, cnt[5:3]}, 32'd1);
        chk("pre_arst_c1", {24'h0, c[15:8]}, 32'h77);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_zero", {16'h0, p_rdy, p_prdy, c_val, cnt, 2'b00}, 32'h0);
        chk("arst_c", {16'h0, c}, 32'h0);
`ifdef STDCORE_RFIFO_MC_ERR_EN
        chk("arst_err", {30'h0, err}, 32'h0);
`endif
        arst_n = 1'b1;
        step();
        chk("arst_release_rdy", {28'h0, p_rdy, p_prdy}, 32'hF);

        // Bounded wait for the output after a push on lane 1.
        p_val = 2'b10;
        p     = 16'h9900;
        step();
        p_val = '0;
        k = 0;
        while (!c_val[1] && k < 5) begin
            step();
            k++;
        end
        chk("wait_cval1_budget", {31'h0, c_val[1]}, 32'd1);
        chk("wait_c1", {24'h0, c[15:8]}, 32'h99);
        c_rdy = 2'b10;
        step();
        c_rdy = '0;
        chk("final_drain", {26'h0, c_val, cnt[5:3], 1'b0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
